// File: rtl/md_sched_if.sv
// md_sched_if: E-stage bundle between the pipeline and the multiply/divide
// sequencer.
//   Start[2:0]  op code from E (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//               5 mthi, 6 mtlo, 7 reserved)
//   Kill        cancels the E instruction this cycle
//   A, B        forwarded rs / rt operands
//   Abort       drops the in-flight op (only when MD_ABORT_EN is defined)
//   Busy        high while an op is in flight
//   HI, LO      architectural HI/LO registers
// The master modport is the pipeline side; the slave modport is md_sched.
interface md_sched_if;
    logic [2:0]  Start;
    logic        Kill;
    logic [31:0] A;
    logic [31:0] B;
`ifdef MD_ABORT_EN
    logic        Abort;
`endif
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

`ifdef MD_ABORT_EN
    modport master (output Start, Kill, A, B, Abort, input Busy, HI, LO);
    modport slave  (input Start, Kill, A, B, Abort, output Busy, HI, LO);
`else
    modport master (output Start, Kill, A, B, input Busy, HI, LO);
    modport slave  (input Start, Kill, A, B, output Busy, HI, LO);
`endif
endinterface

// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide sequencer for the E stage; owns HI/LO.
// The result is computed at issue and held in pending registers. A counter
// then models the latency. HI/LO are committed together on the edge where
// Busy falls.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   md     md_sched_if.slave (Start, Kill, A, B, [Abort], Busy, HI, LO)
// Optional feature: define MD_ABORT_EN to add the Abort input. Abort drops
// the in-flight op, and in IDLE it masks Start.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    md_sched_if.slave   md
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic signed [31:0] ph;
    logic signed [31:0] pl;
    logic               dz;      // pending op was a divide by zero: no commit
    logic               busy;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic               abort;

`ifdef MD_ABORT_EN
    assign abort = md.Abort;
`else
    assign abort = 1'b0;
`endif

    assign md.Busy = busy;
    assign md.HI   = hi;
    assign md.LO   = lo;

    // 64-bit product. Only the low 64 bits of the signed product are kept,
    // which is exact for sign-extended 32-bit operands.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            p  = sa * sb;
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        return p;
    endfunction

    // Returns {remainder, quotient}. Signed division is done on magnitudes,
    // then sign-corrected: the quotient truncates toward zero and the
    // remainder follows the dividend. The magnitude of 0x80000000 is still
    // 0x80000000 as an unsigned value, so 0x80000000 / -1 wraps to
    // 0x80000000 with a remainder of 0.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        logic        nq;
        logic        nr;
        nr = sgn & a[31];
        nq = sgn & (a[31] ^ b[31]);
        ma = nr ? -a : a;
        mb = (sgn & b[31]) ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        return {(nr ? -r : r), (nq ? -q : q)};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            ph    <= '0;
            pl    <= '0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!md.Kill && !abort) begin
                        case (md.Start)
                            3'd1, 3'd2: begin
                                {ph, pl} <= mul64(md.A, md.B, md.Start == 3'd1);
                                dz       <= 1'b0;
                                cnt      <= CNT_W'(MULT_CYCLES);
                                busy     <= 1'b1;
                                state    <= RUN;
                            end
                            3'd3, 3'd4: begin
                                if (md.B != '0)
                                    {ph, pl} <= div64(md.A, md.B, md.Start == 3'd3);
                                dz    <= (md.B == '0);
                                cnt   <= CNT_W'(DIV_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            3'd5:    hi <= md.A;
                            3'd6:    lo <= md.A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Start and Kill are ignored while running: the op in
                    // flight is older than anything behind it in E.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            if (!dz) begin
                                hi <= ph;
                                lo <= pl;
                            end
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched. It covers reset,
// mult/multu/div/divu, mthi/mtlo, Kill, Start during RUN and divide corner
// cases. When MD_ABORT_EN is defined, it also covers Abort.
module tb_md_sched;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    md_sched_if mif ();

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op and then checks that Busy stays high for exactly `cycles`
    // cycles. HI/LO must hold their old values until Busy falls, and must
    // show the new values at that point.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles,
                          input logic [31:0] hi_old, input logic [31:0] lo_old,
                          input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        mif.Start = op;
        mif.A     = a;
        mif.B     = b;
        tick();
        mif.Start = 3'd0;
        mif.A     = 32'h1234_5678;  // operands after issue must not matter
        mif.B     = 32'h0000_0001;
        for (int i = 0; i < cycles; i++) begin
            chk({tag, "_busy"}, {31'd0, mif.Busy}, 32'd1);
            chk({tag, "_hold_hi"}, mif.HI, hi_old);
            chk({tag, "_hold_lo"}, mif.LO, lo_old);
            tick();
        end
        chk({tag, "_busy_fall"}, {31'd0, mif.Busy}, 32'd0);
        chk({tag, "_hi"}, mif.HI, hi_exp);
        chk({tag, "_lo"}, mif.LO, lo_exp);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        mif.Start = 3'd0;
        mif.Kill  = 1'b0;
        mif.A     = '0;
        mif.B     = '0;
`ifdef MD_ABORT_EN
        mif.Abort = 1'b0;
`endif
        tick();
        tick();
        chk("rst_busy", {31'd0, mif.Busy}, 32'd0);
        chk("rst_hi", mif.HI, 32'd0);
        chk("rst_lo", mif.LO, 32'd0);
        reset = 1'b1;
        tick();

        // -1 * 3 signed = -3; unsigned 0xFFFFFFFF*3 = 0x2_FFFFFFFD
        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd3, 5, 32'd0, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               32'h0000_0002, 32'hFFFF_FFFD);
        // -7 / 2 = -3 rem -1
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0002, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // 7 / -2 = -3 rem 1
        run_op("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               32'h0000_0001, 32'hFFFF_FFFD);
        // INT_MIN / -1 wraps
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0001,
               32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
        // unsigned 0xFFFFFFF9 / 2 = 0x7FFFFFFC rem 1
        run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0000, 32'h8000_0000,
               32'h0000_0001, 32'h7FFF_FFFC);

        // mthi / mtlo: single-cycle, Busy stays low
        mif.Start = 3'd5;
        mif.A     = 32'h11;
        tick();
        chk("mthi_busy", {31'd0, mif.Busy}, 32'd0);
        chk("mthi_hi", mif.HI, 32'h11);
        chk("mthi_lo", mif.LO, 32'h7FFF_FFFC);
        mif.Start = 3'd6;
        mif.A     = 32'h22;
        tick();
        chk("mtlo_busy", {31'd0, mif.Busy}, 32'd0);
        chk("mtlo_hi", mif.HI, 32'h11);
        chk("mtlo_lo", mif.LO, 32'h22);

        // divide by zero: full latency, no commit
        run_op("divu_z", 3'd4, 32'd99, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22);

        // Reserved op code 7 does nothing
        mif.Start = 3'd7;
        mif.A     = 32'hDEAD_BEEF;
        tick();
        mif.Start = 3'd0;
        chk("op7_busy", {31'd0, mif.Busy}, 32'd0);
        chk("op7_hi", mif.HI, 32'h11);
        chk("op7_lo", mif.LO, 32'h22);

        // Kill suppresses issue
        mif.Start = 3'd1;
        mif.Kill  = 1'b1;
        mif.A     = 32'd5;
        mif.B     = 32'd5;
        tick();
        chk("kill_busy", {31'd0, mif.Busy}, 32'd0);
        mif.Start = 3'd5;
        tick();
        mif.Start = 3'd0;
        mif.Kill  = 1'b0;
        tick();
        chk("kill_busy2", {31'd0, mif.Busy}, 32'd0);
        chk("kill_hi", mif.HI, 32'h11);
        chk("kill_lo", mif.LO, 32'h22);

        // Start, mthi and Kill during a div RUN are ignored: 100/7 = 14 rem 2
        mif.Start = 3'd3;
        mif.A     = 32'd100;
        mif.B     = 32'd7;
        tick();
        mif.Start = 3'd0;
        tick();
        tick();
        mif.Start = 3'd1;
        mif.Kill  = 1'b1;
        mif.A     = 32'd3;
        mif.B     = 32'd3;
        tick();
        mif.Start = 3'd5;
        mif.Kill  = 1'b0;
        tick();
        mif.Start = 3'd0;
        for (int i = 0; i < 4; i++) tick();
        chk("ovl_busy9", {31'd0, mif.Busy}, 32'd1);
        chk("ovl_hi9", mif.HI, 32'h11);
        tick();
        chk("ovl_busy10", {31'd0, mif.Busy}, 32'd1);
        tick();
        chk("ovl_busy_fall", {31'd0, mif.Busy}, 32'd0);
        chk("ovl_hi", mif.HI, 32'd2);
        chk("ovl_lo", mif.LO, 32'd14);
        tick();
        chk("ovl_idle", {31'd0, mif.Busy}, 32'd0);

`ifdef MD_ABORT_EN
        // Abort in cycle 4 of a mult
        mif.Start = 3'd1;
        mif.A     = 32'd6;
        mif.B     = 32'd7;
        tick();
        mif.Start = 3'd0;
        tick();
        tick();
        tick();
        chk("abt_busy4", {31'd0, mif.Busy}, 32'd1);
        mif.Abort = 1'b1;
        tick();
        mif.Abort = 1'b0;
        chk("abt_busy", {31'd0, mif.Busy}, 32'd0);
        chk("abt_hi", mif.HI, 32'd2);
        chk("abt_lo", mif.LO, 32'd14);
        tick();
        tick();
        chk("abt_hi2", mif.HI, 32'd2);
        chk("abt_lo2", mif.LO, 32'd14);
        // Abort in IDLE masks Start
        mif.Start = 3'd6;
        mif.A     = 32'h55;
        mif.Abort = 1'b1;
        tick();
        mif.Start = 3'd0;
        mif.Abort = 1'b0;
        chk("abt_idle_lo", mif.LO, 32'd14);
`endif

        // Asynchronous reset three cycles into a div
        mif.Start = 3'd3;
        mif.A     = 32'd50;
        mif.B     = 32'd5;
        tick();
        mif.Start = 3'd0;
        tick();
        tick();
        chk("pre_rst_busy", {31'd0, mif.Busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, mif.Busy}, 32'd0);
        chk("arst_hi", mif.HI, 32'd0);
        chk("arst_lo", mif.LO, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("arst_lost_busy", {31'd0, mif.Busy}, 32'd0);
        chk("arst_lost_lo", mif.LO, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
